button_ctrl: RTL and testbench

- Parametrised, multi-channel successor to the team's single-button push/press/3-second-hold logic.
- Synchronises, debounces and classifies N_BTN raw mechanical button inputs.
- Produces per-channel debounced level, press/release pulses, long-press detection and optional auto-repeat.
- Replaces per-button clock dividers with one shared sample-tick enable, so everything runs on clk_in with no derived clocks.

---
 rtl/button_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_button_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_ctrl.sv
// button_ctrl: per-channel synchroniser, debouncer and push/release/long-press classifier on one sample tick.
// Defining BUTTON_CTRL_AUTO_REPEAT_EN adds auto-repeat pulses while a button is held past long-press.
module button_ctrl #(
   parameter int N_BTN        = 4,
   parameter int TICK_DIV     = 25000000,
   parameter int DEB_SAMPLES  = 2,
   parameter int LONG_TICKS   = 12,
   parameter int REPEAT_TICKS = 2,
   parameter int ACTIVE_LOW   = 0
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] push_pulse,
   output logic [N_BTN-1:0] rel_pulse,
   output logic [N_BTN-1:0] long_pulse,
   output logic [N_BTN-1:0] long_level,
   output logic [N_BTN-1:0] rpt_pulse
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int AW = $clog2(DEB_SAMPLES + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [AW-1:0] DEB_LAST  = AW'(DEB_SAMPLES - 1);
   localparam logic [7:0]    LONG_LAST = 8'(LONG_TICKS - 1);
   localparam bit PARAMS_OK = (N_BTN >= 1) && (N_BTN <= 16) && (TICK_DIV >= 2) &&
                              (DEB_SAMPLES >= 1) && (DEB_SAMPLES <= 15) &&
                              (LONG_TICKS >= 1) && (LONG_TICKS <= 255) &&
                              (REPEAT_TICKS >= 1) && (REPEAT_TICKS <= 255);

   if (!PARAMS_OK) begin : g_param_check
      $error("button_ctrl: parameter out of range");
   end

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } state_t;

   logic [N_BTN-1:0] raw_s;
   logic [N_BTN-1:0] sync1_r;
   logic [N_BTN-1:0] sync2_r;
   logic [TW-1:0]    tick_cnt_r;
   logic             tick_s;

   assign raw_s  = btn_raw ^ {N_BTN{ACTIVE_LOW != 0}};
   assign tick_s = (tick_cnt_r == TICK_LAST);

   // Two-flop synchroniser, cleared to "not pressed"
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= {N_BTN{1'b0}};
         sync2_r <= {N_BTN{1'b0}};
      end else begin
         sync1_r <= raw_s;
         sync2_r <= sync1_r;
      end
   end

   // Shared sample-tick divider
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt_r <= {TW{1'b0}};
      end else if (tick_s) begin
         tick_cnt_r <= {TW{1'b0}};
      end else begin
         tick_cnt_r <= tick_cnt_r + TW'(1);
      end
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      logic [AW-1:0] agree_r, agree_s;
      logic          level_r, level_s, press_s, release_s;
      state_t        state_r, state_s;
      logic [7:0]    hold_r, hold_s;
      logic          long_lvl_r, long_lvl_s;
      logic          push_r, push_s, rel_r, rel_s, long_r, long_s;

      // Debounce: the level flips only after DEB_SAMPLES consecutive disagreeing ticks
      always_comb begin
         agree_s   = agree_r;
         level_s   = level_r;
         press_s   = 1'b0;
         release_s = 1'b0;
         if (tick_s && (sync2_r[i] != level_r)) begin
            if (agree_r == DEB_LAST) begin
               agree_s   = {AW{1'b0}};
               level_s   = ~level_r;
               press_s   = ~level_r;
               release_s = level_r;
            end else begin
               agree_s = agree_r + AW'(1);
            end
         end else if (tick_s) begin
            agree_s = {AW{1'b0}};
         end else begin
            agree_s = agree_r;
         end
      end

      // Channel FSM; release has priority over a long-press landing on the same tick
      always_comb begin
         state_s    = state_r;
         hold_s     = hold_r;
         long_lvl_s = long_lvl_r;
         push_s     = 1'b0;
         rel_s      = 1'b0;
         long_s     = 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (press_s) begin
                  state_s = ST_PRESSED;
                  hold_s  = 8'd0;
                  push_s  = 1'b1;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_PRESSED: begin
               if (release_s) begin
                  state_s = ST_IDLE;
                  rel_s   = 1'b1;
               end else if (tick_s && (hold_r == LONG_LAST)) begin
                  state_s    = ST_HELD;
                  hold_s     = hold_r + 8'd1;
                  long_s     = 1'b1;
                  long_lvl_s = 1'b1;
               end else if (tick_s) begin
                  hold_s = hold_r + 8'd1;
               end else begin
                  hold_s = hold_r;
               end
            end
            ST_HELD: begin
               if (release_s) begin
                  state_s    = ST_IDLE;
                  rel_s      = 1'b1;
                  long_lvl_s = 1'b0;
               end else if (tick_s && (hold_r != 8'hFF)) begin
                  hold_s = hold_r + 8'd1;
               end else begin
                  hold_s = hold_r;
               end
            end
            default: begin
               state_s    = ST_IDLE;
               hold_s     = 8'd0;
               long_lvl_s = 1'b0;
            end
         endcase
      end

      // Channel debounce, FSM and output registers
      always_ff @(posedge clk_in or negedge rst_n) begin
         if (!rst_n) begin
            agree_r    <= {AW{1'b0}};
            level_r    <= 1'b0;
            state_r    <= ST_IDLE;
            hold_r     <= 8'd0;
            long_lvl_r <= 1'b0;
            push_r     <= 1'b0;
            rel_r      <= 1'b0;
            long_r     <= 1'b0;
         end else begin
            agree_r    <= agree_s;
            level_r    <= level_s;
            state_r    <= state_s;
            hold_r     <= hold_s;
            long_lvl_r <= long_lvl_s;
            push_r     <= push_s;
            rel_r      <= rel_s;
            long_r     <= long_s;
         end
      end

      assign btn_level[i]  = level_r;
      assign push_pulse[i] = push_r;
      assign rel_pulse[i]  = rel_r;
      assign long_pulse[i] = long_r;
      assign long_level[i] = long_lvl_r;

`ifdef BUTTON_CTRL_AUTO_REPEAT_EN
      localparam logic [7:0] RPT_LAST = 8'(REPEAT_TICKS - 1);
      logic [7:0] rpt_cnt_r, rpt_cnt_s;
      logic       rpt_r, rpt_s;

      // Repeat counter restarts on long-press; a release tick never repeats
      always_comb begin
         rpt_cnt_s = rpt_cnt_r;
         rpt_s     = 1'b0;
         if (long_s) begin
            rpt_cnt_s = 8'd0;
         end else if ((state_r == ST_HELD) && tick_s && !release_s) begin
            if (rpt_cnt_r == RPT_LAST) begin
               rpt_cnt_s = 8'd0;
               rpt_s     = 1'b1;
            end else begin
               rpt_cnt_s = rpt_cnt_r + 8'd1;
            end
         end else begin
            rpt_cnt_s = rpt_cnt_r;
         end
      end

      // Repeat counter and pulse register
      always_ff @(posedge clk_in or negedge rst_n) begin
         if (!rst_n) begin
            rpt_cnt_r <= 8'd0;
            rpt_r     <= 1'b0;
         end else begin
            rpt_cnt_r <= rpt_cnt_s;
            rpt_r     <= rpt_s;
         end
      end

      assign rpt_pulse[i] = rpt_r;
`else
      assign rpt_pulse[i] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_button_ctrl.sv
// tb_button_ctrl: scoreboard bench driving an active-high and an active-low button_ctrl with the same
// logical stimulus; both must produce identical pulses at the cycles derived from the tick phase.
module tb_button_ctrl;

   localparam int NB  = 2;
   localparam int TD  = 4;
   localparam int DEB = 2;
   localparam int LT  = 5;
   localparam int RT  = 2;
   // Stimulus driven on a cycle with cyc%TD==1 reaches the synchroniser output just before a tick,
   // so the debounced decision lands DEB-1 ticks after that first tick.
   localparam int PRESS_LAT = 3 + (DEB - 1) * TD;
   localparam int LAT_MAX   = 3 + DEB * TD;
   localparam int K_PUSH = 0, K_REL = 1, K_LONG = 2, K_RPT = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NB-1:0] btn_raw;
   logic [NB-1:0] btn_raw_n;
   logic [NB-1:0] level [2];
   logic [NB-1:0] push  [2];
   logic [NB-1:0] rel   [2];
   logic [NB-1:0] lng   [2];
   logic [NB-1:0] llev  [2];
   logic [NB-1:0] rpt   [2];

   typedef struct {
      int d;
      int k;
      int ch;
      int lo;
      int hi;
   } exp_t;

   typedef struct {
      int mask;
      int hold;
      int n_long;
      int n_rpt;
   } press_t;

   exp_t   sb[$];
   press_t tbl [6];
   int     errors = 0;
   int     checks = 0;
   int     cyc;

   always #5 clk = ~clk;
   assign btn_raw_n = ~btn_raw;

   button_ctrl #(.N_BTN(NB), .TICK_DIV(TD), .DEB_SAMPLES(DEB), .LONG_TICKS(LT),
                 .REPEAT_TICKS(RT), .ACTIVE_LOW(0)) dut_hi (
      .clk_in(clk), .rst_n(rst_n), .btn_raw(btn_raw),
      .btn_level(level[0]), .push_pulse(push[0]), .rel_pulse(rel[0]),
      .long_pulse(lng[0]), .long_level(llev[0]), .rpt_pulse(rpt[0]));

   button_ctrl #(.N_BTN(NB), .TICK_DIV(TD), .DEB_SAMPLES(DEB), .LONG_TICKS(LT),
                 .REPEAT_TICKS(RT), .ACTIVE_LOW(1)) dut_lo (
      .clk_in(clk), .rst_n(rst_n), .btn_raw(btn_raw_n),
      .btn_level(level[1]), .push_pulse(push[1]), .rel_pulse(rel[1]),
      .long_pulse(lng[1]), .long_level(llev[1]), .rpt_pulse(rpt[1]));

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic string kname(int k);
      case (k)
         K_PUSH:  return "push_pulse";
         K_REL:   return "rel_pulse";
         K_LONG:  return "long_pulse";
         default: return "rpt_pulse";
      endcase
   endfunction

   function automatic logic [NB-1:0] pulses(int d, int k);
      case (k)
         K_PUSH:  return push[d];
         K_REL:   return rel[d];
         K_LONG:  return lng[d];
         default: return rpt[d];
      endcase
   endfunction

   // Every observed pulse must consume a matching expectation; overdue expectations are misses.
   always @(negedge clk) begin
      int idx;
      logic [NB-1:0] p;
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 4; k++) begin
            p = pulses(d, k);
            for (int c = 0; c < NB; c++) begin
               if (p[c]) begin
                  idx = -1;
                  for (int q = 0; q < sb.size(); q++)
                     if (idx < 0 && sb[q].d == d && sb[q].k == k && sb[q].ch == c &&
                         cyc >= sb[q].lo && cyc <= sb[q].hi) idx = q;
                  checks++;
                  if (idx >= 0) sb.delete(idx);
                  else begin
                     errors++;
                     $display("FAIL unexpected %s dut%0d ch%0d: pulse at cycle %0d, required none",
                              kname(k), d, c, cyc);
                  end
               end
            end
         end
      end
      for (int q = sb.size() - 1; q >= 0; q--) begin
         if (sb[q].hi < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing %s dut%0d ch%0d: no pulse by cycle %0d, required in %0d..%0d",
                     kname(sb[q].k), sb[q].d, sb[q].ch, cyc, sb[q].lo, sb[q].hi);
            sb.delete(q);
         end
      end
   end

   task automatic expect_ev(input int k, input int mask, input int lo, input int hi);
      exp_t e;
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < NB; c++)
            if (mask[c]) begin
               e.d = d; e.k = k; e.ch = c; e.lo = lo; e.hi = hi;
               sb.push_back(e);
            end
   endtask

   task automatic check_out(input string name, input int d, input logic [NB*6-1:0] got,
                            input logic [NB*6-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s dut%0d: got %b, required %b", name, d, got, want);
      end
   endtask

   task automatic check_all_zero(input string name);
      for (int d = 0; d < 2; d++)
         check_out(name, d, {level[d], push[d], rel[d], lng[d], llev[d], rpt[d]}, {(NB*6){1'b0}});
   endtask

   task automatic align();
      do @(negedge clk); while (cyc % TD != 1);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (12) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s drain: %0d expected pulses pending, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int j, nr, ll;
      tbl[0] = '{1, 12, 0, 0};   // short press, 3 ticks
      tbl[1] = '{2, 60, 1, 4};   // long press, repeats every RT ticks until release
      tbl[2] = '{1, 20, 0, 0};   // release decided on the tick hold would reach LT
      tbl[3] = '{3, 24, 1, 0};   // both channels: long one tick before release
      tbl[4] = '{3, 28, 1, 0};   // release lands on the first repeat tick
      tbl[5] = '{1, 36, 1, 1};   // one repeat, second suppressed by release

      // Reset with both buttons down, then release reset
      rst_n   = 1'b0;
      btn_raw = 2'b11;
      repeat (20) @(negedge clk);
      check_all_zero("reset_outputs");
      rst_n = 1'b1;
      expect_ev(K_PUSH, 3, PRESS_LAT, LAT_MAX);
      repeat (13) @(negedge clk);
      j = cyc;
      btn_raw = 2'b00;
      expect_ev(K_REL, 3, j + PRESS_LAT, j + PRESS_LAT);
      drain("reset_release");

      // Bounce faster than the tick: never two agreeing samples in a row
      do @(negedge clk); while (cyc % TD != 2);
      for (int c = 0; c < 40; c++) begin
         btn_raw[0] = ((c / 3) % 2 == 0);
         @(negedge clk);
      end
      btn_raw = 2'b00;
      drain("bounce");
      for (int d = 0; d < 2; d++)
         check_out("bounce_level", d, {{(NB*5){1'b0}}, level[d]}, {(NB*6){1'b0}});

      // Press table
      for (int r = 0; r < 6; r++) begin
`ifdef BUTTON_CTRL_AUTO_REPEAT_EN
         nr = tbl[r].n_rpt;
`else
         nr = 0;
`endif
         ll = (tbl[r].n_long != 0) ? tbl[r].mask : 0;
         align();
         j = cyc;
         btn_raw = NB'(tbl[r].mask);
         expect_ev(K_PUSH, tbl[r].mask, j + PRESS_LAT, j + PRESS_LAT);
         if (tbl[r].n_long != 0)
            expect_ev(K_LONG, tbl[r].mask, j + PRESS_LAT + LT * TD, j + PRESS_LAT + LT * TD);
         for (int m = 1; m <= nr; m++)
            expect_ev(K_RPT, tbl[r].mask, j + PRESS_LAT + LT * TD + m * RT * TD,
                      j + PRESS_LAT + LT * TD + m * RT * TD);
         expect_ev(K_REL, tbl[r].mask, j + tbl[r].hold + PRESS_LAT, j + tbl[r].hold + PRESS_LAT);
         repeat (tbl[r].hold) @(negedge clk);
         btn_raw = 2'b00;
         repeat (PRESS_LAT - 1) @(negedge clk);
         for (int d = 0; d < 2; d++)
            check_out($sformatf("row%0d_before_release", r), d,
                      {{(NB*4){1'b0}}, level[d], llev[d]},
                      {{(NB*4){1'b0}}, NB'(tbl[r].mask), NB'(ll)});
         drain($sformatf("row%0d", r));
         for (int d = 0; d < 2; d++)
            check_out($sformatf("row%0d_after_release", r), d,
                      {{(NB*4){1'b0}}, level[d], llev[d]}, {(NB*6){1'b0}});
      end

      // Reset while HELD: outputs clear at once, no release pulse, fresh press afterwards
      align();
      j = cyc;
      btn_raw = 2'b10;
      expect_ev(K_PUSH, 2, j + PRESS_LAT, j + PRESS_LAT);
      expect_ev(K_LONG, 2, j + PRESS_LAT + LT * TD, j + PRESS_LAT + LT * TD);
      repeat (PRESS_LAT + LT * TD + 3) @(negedge clk);
      for (int d = 0; d < 2; d++)
         check_out("held_before_reset", d, {{(NB*5){1'b0}}, llev[d]}, {{(NB*5){1'b0}}, 2'b10});
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL held_pending: %0d expected pulses pending, required 0", sb.size());
      end
      sb.delete();
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_reset_outputs");
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      expect_ev(K_PUSH, 2, PRESS_LAT, LAT_MAX);
      repeat (13) @(negedge clk);
      j = cyc;
      btn_raw = 2'b00;
      expect_ev(K_REL, 2, j + PRESS_LAT, j + PRESS_LAT);
      drain("after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
